// File: rtl/switch_allocator.sv
// Switch allocator: each output port runs an IDLE/BUSY round-robin arbiter over the rx
// requests that target it, then forwards grant, buffer address and data while it holds an owner.

module switch_allocator_lane #(
  parameter int PORTS     = 5,
  parameter int CHNL_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PORTS-1:0]     cand,
  input  logic [PORTS-1:0]     in_req,
  output logic                 busy,
  output logic [CHNL_BITS-1:0] owner,
  output logic                 out_req,
  output logic [CHNL_BITS-1:0] out_chnl
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CHNL_BITS-1:0] owner_q, owner_d, rr_q, rr_d, pick_idx;
  logic                 pick_vld, owner_req;
  int                   idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  // Round-robin scan starting at rr_q; only meaningful while idle.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    owner_req = 1'b0;
    idx       = 0;
    for (int i = 0; i < PORTS; i++)
      if (owner_q == CHNL_BITS'(i)) owner_req = in_req[i];
    if (state_q == IDLE) begin
      for (int k = 0; k < PORTS; k++) begin
        idx = int'(rr_q) + k;
        if (idx >= PORTS) idx = idx - PORTS;
        for (int i = 0; i < PORTS; i++)
          if (!pick_vld && cand[i] && idx == i) begin
            pick_vld = 1'b1;
            pick_idx = CHNL_BITS'(i);
          end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    case (state_q)
      IDLE: if (pick_vld) begin
        state_d = BUSY;
        owner_d = pick_idx;
      end
      BUSY: if (!owner_req) begin
        state_d = IDLE;
        rr_d    = (owner_q == CHNL_BITS'(PORTS - 1)) ? '0 : owner_q + CHNL_BITS'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == BUSY);
    owner    = owner_q;
    out_req  = busy;
    out_chnl = busy ? owner_q : '0;
  end
endmodule

module switch_allocator #(
  parameter int PORTS     = 5,
  parameter int CHNL_BITS = 3,
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PORTS-1:0]           in_req,
  input  logic [PORTS*CHNL_BITS-1:0] in_chnl,
  output logic [PORTS-1:0]           in_gnt,
  output logic [PORTS*ADDR_BITS-1:0] in_buf_addr,
  input  logic [PORTS*DATA_BITS-1:0] in_buf_data,
  output logic [PORTS-1:0]           out_req,
  output logic [PORTS*CHNL_BITS-1:0] out_chnl,
  input  logic [PORTS-1:0]           out_gnt,
  input  logic [PORTS*ADDR_BITS-1:0] out_buf_addr,
  output logic [PORTS*DATA_BITS-1:0] out_buf_data
);
  logic [PORTS-1:0][CHNL_BITS-1:0] chnl_a, owner_a, out_chnl_a;
  logic [PORTS-1:0][ADDR_BITS-1:0] in_addr_a, out_addr_a;
  logic [PORTS-1:0][DATA_BITS-1:0] in_data_a, out_data_a;
  logic [PORTS-1:0][PORTS-1:0]     cand;
  logic [PORTS-1:0]                busy, owned;

  assign chnl_a       = in_chnl;
  assign out_addr_a   = out_buf_addr;
  assign in_data_a    = in_buf_data;
  assign out_chnl     = out_chnl_a;
  assign in_buf_addr  = in_addr_a;
  assign out_buf_data = out_data_a;

  // An input names exactly one output, so candidate sets never overlap; masking inputs
  // already owned keeps a re-targeted input from holding two outputs at once.
  always_comb begin
    owned = '0;
    cand  = '0;
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        if (busy[j] && owner_a[j] == CHNL_BITS'(i)) owned[i] = 1'b1;
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        cand[j][i] = in_req[i] && (chnl_a[i] == CHNL_BITS'(j)) && !owned[i];
  end

  for (genvar j = 0; j < PORTS; j++) begin : g_lane
    switch_allocator_lane #(.PORTS(PORTS), .CHNL_BITS(CHNL_BITS)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .cand     (cand[j]),
      .in_req   (in_req),
      .busy     (busy[j]),
      .owner    (owner_a[j]),
      .out_req  (out_req[j]),
      .out_chnl (out_chnl_a[j])
    );
  end

  always_comb begin
    in_gnt     = '0;
    in_addr_a  = '0;
    out_data_a = '0;
    for (int j = 0; j < PORTS; j++)
      for (int i = 0; i < PORTS; i++)
        if (busy[j] && owner_a[j] == CHNL_BITS'(i)) begin
          in_gnt[i]     = out_gnt[j];
          in_addr_a[i]  = out_addr_a[j];
          out_data_a[j] = in_data_a[i];
        end
  end
endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: stimulus queues expected grants, a negedge monitor
// matches every out_req rise against the queue; forwarding and reset are checked inline.

module tb_switch_allocator;
  localparam int P  = 5;
  localparam int CB = 3;
  localparam int AB = 3;
  localparam int DB = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [P-1:0]    in_req, in_gnt, out_req, out_gnt;
  logic [P*CB-1:0] in_chnl, out_chnl;
  logic [P*AB-1:0] in_buf_addr, out_buf_addr;
  logic [P*DB-1:0] in_buf_data, out_buf_data;

  typedef struct {int port; int chnl; int cyc;} exp_t;
  exp_t   expq[$];
  exp_t   mon_e;
  logic [P-1:0] prev_req = '0;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;
  int     own[4] = '{0, 1, 3, 0};

  switch_allocator #(.PORTS(P), .CHNL_BITS(CB), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk(clk), .reset(reset),
    .in_req(in_req), .in_chnl(in_chnl), .in_gnt(in_gnt),
    .in_buf_addr(in_buf_addr), .in_buf_data(in_buf_data),
    .out_req(out_req), .out_chnl(out_chnl), .out_gnt(out_gnt),
    .out_buf_addr(out_buf_addr), .out_buf_data(out_buf_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_req(input int i, input int ch);
    in_req[i] = 1'b1;
    in_chnl[i*CB +: CB] = CB'(ch);
  endtask

  task automatic push(input int p, input int c, input int t);
    exp_t e;
    e.port = p; e.chnl = c; e.cyc = t;
    expq.push_back(e);
  endtask

  // Grant monitor: each rising out_req must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int j = 0; j < P; j++)
      if (out_req[j] && !prev_req[j]) begin
        checks++;
        if (expq.size() == 0) begin
          failures++;
          $display("FAIL grant_unexpected port=%0d chnl=%0d cyc=%0d expected=none",
                   j, out_chnl[j*CB +: CB], cyc);
        end else begin
          mon_e = expq.pop_front();
          if (mon_e.port != j || mon_e.chnl != int'(out_chnl[j*CB +: CB]) || mon_e.cyc != cyc) begin
            failures++;
            $display("FAIL grant_match actual port=%0d chnl=%0d cyc=%0d expected port=%0d chnl=%0d cyc=%0d",
                     j, out_chnl[j*CB +: CB], cyc, mon_e.port, mon_e.chnl, mon_e.cyc);
          end
        end
      end
    prev_req = out_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    in_req       = '0;
    in_chnl      = '0;
    out_gnt      = '1;
    out_buf_addr = '1;
    in_buf_data  = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    tick(2);
    chk("rst_out_req", out_req, 0);
    chk("rst_out_chnl", out_chnl, 0);
    chk("rst_in_gnt", in_gnt, 0);
    chk("rst_in_addr", in_buf_addr, 0);
    chk("rst_out_data", out_buf_data, 0);
    out_gnt      = '0;
    out_buf_addr = '0;
    reset        = 1'b0;
    tick(1);

    // Contention on output 1: grants 0,1,3,0 with a one-cycle idle gap.
    set_req(0, 1); set_req(1, 1); set_req(3, 1);
    push(1, 0, cyc + 1);
    tick(1);
    for (int n = 0; n < 3; n++) begin
      out_gnt[1] = 1'b1;
      #1;
      chk("cont_gnt", in_gnt, 5'(1 << own[n]));
      tick(7);
      in_req[own[n]] = 1'b0;
      tick(1);
      chk("cont_idle_gap", out_req[1], 0);
      chk("cont_gap_gnt", in_gnt, 0);
      in_req[own[n]] = 1'b1;
      push(1, own[n+1], cyc + 1);
      tick(1);
    end
    #1;
    chk("cont_last_gnt", in_gnt, 5'b00001);
    in_req = '0; out_gnt = '0;
    tick(2);

    // Single request 2 -> 4 with forwarding; out_gnt on idle output 0 ignored.
    set_req(2, 4);
    push(4, 2, cyc + 1);
    tick(1);
    out_gnt[4] = 1'b1;
    out_gnt[0] = 1'b1;
    out_buf_addr[4*AB +: AB] = 3'd5;
    #1;
    chk("single_out_chnl", out_chnl, 15'(2 << 12));
    chk("single_in_gnt", in_gnt, 5'b00100);
    chk("single_in_addr", in_buf_addr, 15'h0140);
    chk("single_out_data", out_buf_data, 40'hA2_0000_0000);
    in_req = '0;
    tick(1);
    chk("single_release", out_req, 0);
    out_gnt = '0; out_buf_addr = '0;
    tick(1);

    // Parallel grants 0 -> 2 and 1 -> 3 on the same edge.
    set_req(0, 2); set_req(1, 3);
    push(2, 0, cyc + 1);
    push(3, 1, cyc + 1);
    tick(1);
    out_gnt[2] = 1'b1;
    out_buf_addr[2*AB +: AB] = 3'd3;
    out_buf_addr[3*AB +: AB] = 3'd6;
    #1;
    chk("par_out_req", out_req, 5'b01100);
    chk("par_in_gnt", in_gnt, 5'b00001);
    chk("par_in_addr", in_buf_addr, 15'h0033);
    chk("par_out_data", out_buf_data, 40'h00_A1A0_0000);
    in_req = '0; out_gnt = '0; out_buf_addr = '0;
    tick(2);

    // Owner retargets while busy: routing stays put.
    set_req(0, 1);
    push(1, 0, cyc + 1);
    tick(1);
    in_chnl[0 +: CB] = 3'd3;
    tick(3);
    chk("chg_out_req", out_req, 5'b00010);
    out_gnt[1] = 1'b1;
    #1;
    chk("chg_in_gnt", in_gnt, 5'b00001);
    in_req = '0; out_gnt = '0;
    tick(2);

    // Out-of-range channel never granted.
    set_req(4, 6);
    for (int n = 0; n < 20; n++) begin
      tick(1);
      chk("inv_no_req", out_req, 0);
    end
    in_req = '0;
    tick(1);

    // Reset mid-packet, then re-grant after release.
    set_req(2, 0);
    push(0, 2, cyc + 1);
    tick(1);
    out_gnt[0] = 1'b1;
    out_buf_addr[0 +: AB] = 3'd2;
    #1;
    chk("rst_pre_gnt", in_gnt, 5'b00100);
    tick(2);
    reset = 1'b1;
    #1;
    chk("rst_mid_out_req", out_req, 0);
    chk("rst_mid_in_gnt", in_gnt, 0);
    chk("rst_mid_in_addr", in_buf_addr, 0);
    chk("rst_mid_out_data", out_buf_data, 0);
    tick(2);
    reset = 1'b0;
    push(0, 2, cyc + 1);
    tick(1);
    #1;
    chk("rst_regrant_gnt", in_gnt, 5'b00100);
    chk("rst_regrant_data", out_buf_data, 40'h00_0000_00A2);
    in_req = '0; out_gnt = '0; out_buf_addr = '0;
    tick(3);
    chk("queue_drained", 64'(expq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
SWITCH_ALLOCATOR -- requirements
Module: switch_allocator

Interface
REQ-001 Parameter PORTS, default 5, number of rx (input) ports and tx (output) ports.
REQ-002 Parameter CHNL_BITS, default 3, width of a channel index; 2^CHNL_BITS SHALL be >= PORTS.
REQ-003 Parameter ADDR_BITS, default 3, rx buffer address width.
REQ-004 Parameter DATA_BITS, default 8, flit width.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_req  input  PORTS  per-rx switch request (rx sw_req).
REQ-008 in_chnl  input  PORTS*CHNL_BITS  per-rx requested output index, slice i = bits [i*CHNL_BITS +: CHNL_BITS].
REQ-009 in_gnt  output  PORTS  per-rx grant (drives rx sw_gnt).
REQ-010 in_buf_addr  output  PORTS*ADDR_BITS  per-rx buffer read address.
REQ-011 in_buf_data  input  PORTS*DATA_BITS  per-rx buffer read data.
REQ-012 out_req  output  PORTS  per-tx request (drives tx sw_req).
REQ-013 out_chnl  output  PORTS*CHNL_BITS  per-tx source index (drives tx sw_chnl).
REQ-014 out_gnt  input  PORTS  per-tx grant (tx sw_gnt).
REQ-015 out_buf_addr  input  PORTS*ADDR_BITS  per-tx buffer read address.
REQ-016 out_buf_data  output  PORTS*DATA_BITS  per-tx buffer read data.

Function
REQ-017 Each output j SHALL run an independent two-state FSM: IDLE, BUSY; state registers: owner[j] (CHNL_BITS), rr_ptr[j] (CHNL_BITS).
REQ-018 Candidate set for output j in IDLE: inputs i with in_req[i]=1, in_chnl slice i = j, and i not owner of any BUSY output.
REQ-019 IDLE with non-empty candidate set: select first candidate scanning i = rr_ptr[j], rr_ptr[j]+1, ... modulo PORTS; latch owner[j]=i; go BUSY.
REQ-020 IDLE with empty candidate set: stay IDLE; rr_ptr unchanged.
REQ-021 out_req[j] and out_chnl[j] SHALL be registered: out_req[j]=1 and out_chnl[j]=owner[j] exactly while state is BUSY; in IDLE both 0.
REQ-022 Grant latency: in_req[i] rising sampled at edge k with output j IDLE and i winning -> out_req[j]=1 after edge k.
REQ-023 While BUSY, combinational forwarding: in_gnt[owner]=out_gnt[j]; in_buf_addr[owner]=out_buf_addr[j]; out_buf_data[j]=in_buf_data[owner].
REQ-024 Inputs not owned by any BUSY output SHALL see in_gnt=0 and in_buf_addr=0; IDLE outputs SHALL drive out_buf_data=0.
REQ-025 BUSY with in_req[owner]=0 sampled at an edge: go IDLE, rr_ptr[j]=(owner+1) modulo PORTS; out_req[j] falls after that edge.
REQ-026 A released output SHALL spend at least one cycle in IDLE before re-granting (no back-to-back grant on the release edge).
REQ-027 Changes of in_chnl[owner] while BUSY SHALL be ignored; owner and routing stay fixed until release.
REQ-028 An input SHALL never be owner of two outputs simultaneously; if two IDLE outputs see the same input as candidate (in_chnl changed), only the output with lowest index j wins that cycle.
REQ-029 in_chnl values >= PORTS SHALL match no output; such a request is never granted and raises no other effect.
REQ-030 Multiple outputs SHALL grant different inputs on the same edge independently.
REQ-031 out_gnt[j] while IDLE SHALL be ignored.

Reset
REQ-032 On reset assertion, immediately: all FSMs IDLE, owner=0, rr_ptr=0, out_req=0, out_chnl=0, hence in_gnt=0, in_buf_addr=0, out_buf_data=0.
REQ-033 Reset mid-transfer SHALL abort ownership without completing the packet; first grant after release of reset follows REQ-019 with rr_ptr=0.

Verification
REQ-034 Single request: in_req[2]=1, in_chnl[2]=4 -> one edge later out_req[4]=1, out_chnl[4]=2; out_gnt[4]=1, out_buf_addr[4]=5 -> in_gnt[2]=1, in_buf_addr[2]=5, out_buf_data[4]=in_buf_data[2] same cycle.
REQ-035 Contention: inputs 0,1,3 all request output 1 held continuously, each drops req for one cycle after 8 flits -> grants 0,1,3,0 in that order, one IDLE cycle between owners.
REQ-036 Parallel: input 0->output 2 and input 1->output 3 same edge -> both out_req rise on same edge, no cross-forwarding of data.
REQ-037 Chnl change while BUSY: input 0 owns output 1, in_chnl[0] changes to 3 -> output 1 stays BUSY with owner 0, output 3 stays IDLE.
REQ-038 Invalid index: in_chnl[4]=6 with PORTS=5 -> no out_req asserts over 20 cycles.
REQ-039 Reset mid-packet at flit 3 -> out_req, in_gnt drop immediately; after release with in_req still high, grant reissued one edge later.
